// File: rtl/falafel_multi_input_buffer.sv
// Multi-channel request ingress buffer: one FIFO per channel, tagged with a queue id,
// merged onto a single output stream by a round-robin arbiter with grant locking.
module falafel_multi_input_buffer #(
  parameter int                     NUM_CH      = 2,
  parameter int                     DEPTH       = 4,
  parameter int                     DATA_W      = 8,
  parameter int                     MSG_ID_SIZE = 4,
  parameter logic [MSG_ID_SIZE-1:0] ID_BASE     = '0,
  parameter int                     AF_THRESH   = DEPTH - 1,
  parameter int                     CNT_W       = $clog2(DEPTH + 1),
  parameter int                     ENTRY_W     = MSG_ID_SIZE + DATA_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [NUM_CH-1:0]          req_val_i,
  output logic [NUM_CH-1:0]          req_rdy_o,
  input  logic [NUM_CH*DATA_W-1:0]   req_data_i,
  output logic                       buffered_req_val_o,
  input  logic                       buffered_req_rdy_i,
  output logic [ENTRY_W-1:0]         buffered_req_data_o,
  output logic [NUM_CH*CNT_W-1:0]    occupancy_o,
  output logic [NUM_CH-1:0]          almost_full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef struct packed {
    logic [MSG_ID_SIZE-1:0] id;
    logic [DATA_W-1:0]      data;
  } alloc_entry_t;

  logic [DATA_W-1:0] mem_q    [NUM_CH][DEPTH];
  logic [CNT_W-1:0]  count_q  [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   lock_ch_q;
  logic              lock_q;

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] pop;
  logic [CH_W-1:0]   grant;
  logic              out_val;
  logic              handshake;
  alloc_entry_t      out_entry;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full channel refuses writes even when it is popped in the same cycle.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      eligible[c]      = (count_q[c] != '0);
      req_rdy_o[c]     = (count_q[c] != CNT_W'(DEPTH));
      wr_en[c]         = req_val_i[c] && req_rdy_o[c] && !flush_i;
      almost_full_o[c] = (count_q[c] >= CNT_W'(AF_THRESH));
      occupancy_o[c*CNT_W +: CNT_W] = count_q[c];
    end
  end

  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = rr_ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && eligible[idx]) begin
        grant = CH_W'(idx);
        found = 1'b1;
      end
    end
    // A stalled grant is held so data and id stay stable until accepted.
    if (lock_q) grant = lock_ch_q;
  end

  assign out_val   = |eligible;
  assign handshake = out_val && buffered_req_rdy_i;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c] = handshake && !flush_i && (grant == CH_W'(c));
    end
    out_entry.id   = ID_BASE + MSG_ID_SIZE'(grant);
    out_entry.data = mem_q[grant][rd_ptr_q[grant]];
    if (!out_val) out_entry = '0;
  end

  assign buffered_req_val_o  = out_val;
  assign buffered_req_data_o = out_entry;

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en[c]) mem_q[c][wr_ptr_q[c]] <= req_data_i[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        count_q[c]  <= '0;
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
      rr_ptr_q  <= '0;
      lock_ch_q <= '0;
      lock_q    <= 1'b0;
    end else if (flush_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        count_q[c]  <= '0;
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
      rr_ptr_q  <= '0;
      lock_ch_q <= '0;
      lock_q    <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_en[c]) wr_ptr_q[c] <= ptr_inc(wr_ptr_q[c]);
        if (pop[c])   rd_ptr_q[c] <= ptr_inc(rd_ptr_q[c]);
        if (wr_en[c] && !pop[c])      count_q[c] <= count_q[c] + 1'b1;
        else if (!wr_en[c] && pop[c]) count_q[c] <= count_q[c] - 1'b1;
      end
      if (handshake) begin
        rr_ptr_q <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
        lock_q   <= 1'b0;
      end else if (out_val) begin
        lock_q    <= 1'b1;
        lock_ch_q <= grant;
      end
    end
  end

endmodule

// File: tb/tb_falafel_multi_input_buffer.sv
// Directed bench for falafel_multi_input_buffer: two instances (DEPTH=4 and DEPTH=3),
// expected output entries queued by the stimulus and checked by per-instance monitors.
module tb_falafel_multi_input_buffer;

  logic        clk = 1'b0;
  logic        rst;

  // Instance A: NUM_CH=2, DEPTH=4, ID_BASE=3
  logic        flush_a;
  logic [1:0]  req_val_a, req_rdy_a;
  logic [15:0] req_data_a;
  logic        bval_a, brdy_a;
  logic [11:0] bdata_a;
  logic [5:0]  occ_a;
  logic [1:0]  af_a;

  // Instance B: NUM_CH=2, DEPTH=3, ID_BASE=3
  logic        flush_b;
  logic [1:0]  req_val_b, req_rdy_b;
  logic [15:0] req_data_b;
  logic        bval_b, brdy_b;
  logic [11:0] bdata_b;
  logic [3:0]  occ_b;
  logic [1:0]  af_b;

  logic [11:0] exp_a_q[$];
  logic [11:0] exp_b_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  falafel_multi_input_buffer #(.NUM_CH(2), .DEPTH(4), .DATA_W(8), .MSG_ID_SIZE(4),
                               .ID_BASE(4'd3)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_a),
    .req_val_i(req_val_a), .req_rdy_o(req_rdy_a), .req_data_i(req_data_a),
    .buffered_req_val_o(bval_a), .buffered_req_rdy_i(brdy_a),
    .buffered_req_data_o(bdata_a), .occupancy_o(occ_a), .almost_full_o(af_a)
  );

  falafel_multi_input_buffer #(.NUM_CH(2), .DEPTH(3), .DATA_W(8), .MSG_ID_SIZE(4),
                               .ID_BASE(4'd3)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_b),
    .req_val_i(req_val_b), .req_rdy_o(req_rdy_b), .req_data_i(req_data_b),
    .buffered_req_val_o(bval_b), .buffered_req_rdy_i(brdy_b),
    .buffered_req_data_o(bdata_b), .occupancy_o(occ_b), .almost_full_o(af_b)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver for instance B channel 0: hold valid until the entry is accepted.
  task automatic write_b(input logic [7:0] d);
    logic acc;
    req_val_b  = 2'b01;
    req_data_b = {8'h00, d};
    for (int n = 0; n < 20; n++) begin
      acc = req_rdy_b[0];
      tick();
      check("occ_b_bound", 32'(occ_b[1:0] <= 2'd3), 32'd1);
      if (acc) break;
      if (n == 19) check("write_b_timeout", 32'd0, 32'd1);
    end
    req_val_b = 2'b00;
  endtask

  // Monitors: pop an expected entry on every accepted output
  always @(negedge clk) begin
    if (!rst && !flush_a && bval_a && brdy_a) begin
      if (exp_a_q.size() == 0) check("out_a_unexpected", 32'(bdata_a), 32'hFFFF_FFFF);
      else check("out_a", 32'(bdata_a), 32'(exp_a_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && !flush_b && bval_b && brdy_b) begin
      if (exp_b_q.size() == 0) check("out_b_unexpected", 32'(bdata_b), 32'hFFFF_FFFF);
      else check("out_b", 32'(bdata_b), 32'(exp_b_q.pop_front()));
    end
  end

  initial begin
    #100000;
    miscompares++;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    rst = 1'b1;
    flush_a = 1'b0; req_val_a = '0; req_data_a = '0; brdy_a = 1'b0;
    flush_b = 1'b0; req_val_b = '0; req_data_b = '0; brdy_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy",   32'(req_rdy_a), 32'h3);
    check("rst_val",   32'(bval_a),    32'h0);
    check("rst_data",  32'(bdata_a),   32'h0);
    check("rst_occ",   32'(occ_a),     32'h0);
    check("rst_af",    32'(af_a),      32'h0);
    rst = 1'b0;
    tick();

    // Single write on ch1 appears next cycle tagged with id 4
    req_val_a = 2'b10; req_data_a = {8'hA5, 8'h00};
    exp_a_q.push_back(12'h4A5);
    tick();
    req_val_a = 2'b00;
    check("t1_occ",  32'(occ_a),   32'h08);
    check("t1_val",  32'(bval_a),  32'h1);
    check("t1_data", 32'(bdata_a), 32'h4A5);
    brdy_a = 1'b1;
    tick();
    brdy_a = 1'b0;
    check("t1_drained_val", 32'(bval_a), 32'h0);
    check("t1_drained_occ", 32'(occ_a),  32'h0);

    // Both channels preloaded with 3 entries; drains alternating ids 3,4
    for (int i = 0; i < 3; i++) begin
      req_val_a  = 2'b11;
      req_data_a = {8'(8'h30 + i), 8'(8'h20 + i)};
      tick();
    end
    req_val_a = 2'b00;
    for (int i = 0; i < 3; i++) begin
      exp_a_q.push_back({4'd3, 8'(8'h20 + i)});
      exp_a_q.push_back({4'd4, 8'(8'h30 + i)});
    end
    check("t3_occ", 32'(occ_a), 32'h1B);
    check("t3_af",  32'(af_a),  32'h3);
    brdy_a = 1'b1;
    repeat (6) tick();
    brdy_a = 1'b0;
    check("t3_empty_occ", 32'(occ_a), 32'h0);
    check("t3_empty_val", 32'(bval_a), 32'h0);
    check("t3_queue", 32'(exp_a_q.size()), 32'd0);

    // Stalled ch1 grant holds even after ch0 (higher priority now) fills
    req_val_a = 2'b10; req_data_a = {8'h41, 8'h00};
    tick();
    req_val_a = 2'b01; req_data_a = {8'h00, 8'h40};
    tick();
    req_val_a = 2'b00;
    check("t4_hold0", 32'(bdata_a), 32'h441);
    tick();
    check("t4_hold1", 32'(bdata_a), 32'h441);
    exp_a_q.push_back(12'h441);
    exp_a_q.push_back(12'h340);
    brdy_a = 1'b1;
    tick();
    check("t4_next", 32'(bdata_a), 32'h340);
    tick();
    brdy_a = 1'b0;
    check("t4_val", 32'(bval_a), 32'h0);

    // Fill ch0 to DEPTH with the output stalled
    for (int i = 0; i < 4; i++) begin
      req_val_a  = 2'b01;
      req_data_a = {8'h00, 8'(8'h10 + i)};
      exp_a_q.push_back({4'd3, 8'(8'h10 + i)});
      tick();
      check("t2_occ", 32'(occ_a[2:0]),   32'(i + 1));
      check("t2_af",  32'(af_a[0]),      32'((i + 1) >= 3));
      check("t2_rdy", 32'(req_rdy_a[0]), 32'((i + 1) < 4));
    end
    req_val_a = 2'b01; req_data_a = {8'h00, 8'h99};
    check("t2_full_rdy", 32'(req_rdy_a[0]), 32'h0);
    tick();
    req_val_a = 2'b00;
    check("t2_refused", 32'(occ_a[2:0]), 32'd4);
    brdy_a = 1'b1;
    repeat (4) tick();
    brdy_a = 1'b0;
    check("t2_empty", 32'(occ_a), 32'h0);
    check("t2_queue", 32'(exp_a_q.size()), 32'd0);

    // Flush with 2+2 entries, then confirm round-robin restarts at ch0
    for (int i = 0; i < 2; i++) begin
      req_val_a  = 2'b11;
      req_data_a = {8'(8'h60 + i), 8'(8'h50 + i)};
      tick();
    end
    req_val_a = 2'b00;
    check("t6_pre_occ", 32'(occ_a), 32'h12);
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    check("t6_flush_val", 32'(bval_a),    32'h0);
    check("t6_flush_occ", 32'(occ_a),     32'h0);
    check("t6_flush_rdy", 32'(req_rdy_a), 32'h3);
    req_val_a = 2'b11; req_data_a = {8'h71, 8'h70};
    exp_a_q.push_back(12'h370);
    exp_a_q.push_back(12'h471);
    tick();
    req_val_a = 2'b00;
    brdy_a = 1'b1;
    repeat (2) tick();
    brdy_a = 1'b0;
    check("t6_post_val", 32'(bval_a), 32'h0);

    // Asynchronous reset mid-stream
    req_val_a = 2'b01; req_data_a = {8'h00, 8'h77};
    tick();
    req_val_a = 2'b00;
    check("t6_pre_rst_val", 32'(bval_a), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_val",  32'(bval_a),    32'h0);
    check("t6_rst_data", 32'(bdata_a),   32'h0);
    check("t6_rst_occ",  32'(occ_a),     32'h0);
    check("t6_rst_rdy",  32'(req_rdy_a), 32'h3);
    tick();
    rst = 1'b0;
    tick();

    // DEPTH=3: fill, then 10 write/read pairs across pointer wraps
    for (int i = 0; i < 3; i++) begin
      req_val_b  = 2'b01;
      req_data_b = {8'h00, 8'(8'h80 + i)};
      exp_b_q.push_back({4'd3, 8'(8'h80 + i)});
      tick();
    end
    req_val_b = 2'b00;
    check("t5_full_occ", 32'(occ_b[1:0]),   32'd3);
    check("t5_full_rdy", 32'(req_rdy_b[0]), 32'h0);
    brdy_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_b_q.push_back({4'd3, 8'(8'h83 + i)});
      write_b(8'(8'h83 + i));
    end
    check("t5_steady_occ", 32'(occ_b[1:0]), 32'd2);
    repeat (2) tick();
    brdy_b = 1'b0;
    check("t5_empty", 32'(occ_b), 32'h0);

    check("final_queue_a", 32'(exp_a_q.size()), 32'd0);
    check("final_queue_b", 32'(exp_b_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
